// File: rtl/nvl3_controle_potencia_if.sv
// Front-panel / timer side bundle of the level-3 magnetron controller.
// The panel drives the requests (master); the controller answers (slave).
interface nvl3_controle_potencia_if #(
    parameter int PWR_W = 4
);
    logic             startn;
    logic             stopn;
    logic             clearn;
    logic             door_closed;
    logic             timer_done;
    logic             tick;
    logic [PWR_W-1:0] power_level;
    logic             mag_on;
    logic             cooking;
    logic             paused;
    logic [PWR_W-1:0] level_q;
    // Debug view of the controller state and the duty-slot counter.
    logic [1:0]       dbg_state;
    logic [PWR_W-1:0] dbg_slot;

    // Level-style signals, no handshake: requests are sampled on every rising
    // clk edge, outputs are valid whenever read (mag_on also follows door_closed live).
    modport master (
        output startn, stopn, clearn, door_closed, timer_done, tick, power_level,
        input  mag_on, cooking, paused, level_q, dbg_state, dbg_slot
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, timer_done, tick, power_level,
        output mag_on, cooking, paused, level_q, dbg_state, dbg_slot
    );
endinterface

// File: rtl/nvl3_controle_potencia.sv
// Level-3 magnetron controller: IDLE/COOK/PAUSE state machine with the power
// level realised as a duty cycle of MAX_LEVEL tick slots.
module nvl3_controle_potencia #(
    parameter int MAX_LEVEL = 10,
    parameter int PWR_W     = 4
) (
    input logic                     clk,
    input logic                     resetn,
    nvl3_controle_potencia_if.slave bus
);
    localparam logic [PWR_W-1:0] MAX_LVL   = PWR_W'(MAX_LEVEL);
    localparam logic [PWR_W-1:0] LAST_SLOT = PWR_W'(MAX_LEVEL - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COOK  = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t           state_q;
    logic [PWR_W-1:0] slot_q;
    logic [PWR_W-1:0] lvl_q;
    logic [PWR_W-1:0] lvl_d;
    logic             cooking_q;
    logic             paused_q;
    logic             start_ok;
    logic             abort;

    // Holding both start and stop is deliberately not a start.
    assign start_ok = !bus.startn && bus.stopn && bus.clearn && bus.door_closed && !bus.timer_done;
    assign abort    = !bus.clearn || bus.timer_done;
    assign lvl_d    = (bus.power_level > MAX_LVL) ? MAX_LVL : bus.power_level;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            lvl_q     <= '0;
            cooking_q <= 1'b0;
            paused_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        state_q   <= COOK;
                        lvl_q     <= lvl_d;
                        slot_q    <= '0;
                        cooking_q <= 1'b1;
                        paused_q  <= 1'b0;
                    end
                end
                COOK: begin
                    if (bus.tick) begin
                        slot_q <= (slot_q == LAST_SLOT) ? '0 : slot_q + 1'b1;
                    end
                    if (abort) begin
                        state_q   <= IDLE;
                        lvl_q     <= '0;
                        cooking_q <= 1'b0;
                        paused_q  <= 1'b0;
                    end else if (!bus.stopn || !bus.door_closed) begin
                        state_q   <= PAUSE;
                        cooking_q <= 1'b0;
                        paused_q  <= 1'b1;
                    end
                end
                PAUSE: begin
                    if (abort) begin
                        state_q   <= IDLE;
                        lvl_q     <= '0;
                        cooking_q <= 1'b0;
                        paused_q  <= 1'b0;
                    end else if (start_ok) begin
                        // Resume keeps the latched level and restarts the window.
                        state_q   <= COOK;
                        slot_q    <= '0;
                        cooking_q <= 1'b1;
                        paused_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    lvl_q     <= '0;
                    cooking_q <= 1'b0;
                    paused_q  <= 1'b0;
                end
            endcase
        end
    end

    // Live door_closed term cuts the magnetron before the state register reacts.
    assign bus.mag_on    = cooking_q && bus.door_closed && (slot_q < lvl_q);
    assign bus.cooking   = cooking_q;
    assign bus.paused    = paused_q;
    assign bus.level_q   = lvl_q;
    assign bus.dbg_state = state_q;
    assign bus.dbg_slot  = slot_q;
endmodule

// File: tb/tb_nvl3_controle_potencia.sv
// Self-checking bench for nvl3_controle_potencia (MAX_LEVEL=10, PWR_W=4).
module tb_nvl3_controle_potencia;
    localparam int PWR_W = 4;
    localparam int W     = PWR_W + 3;
    localparam int NV    = 19;

    logic clk;
    logic resetn;
    int   checks;
    int   errors;

    nvl3_controle_potencia_if #(.PWR_W(PWR_W)) bus ();

    nvl3_controle_potencia #(.MAX_LEVEL(10), .PWR_W(PWR_W)) dut (
        .clk   (clk),
        .resetn(resetn),
        .bus   (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- vectors ----------------
    typedef struct {
        logic             sn, pn, cn, dr, tm, tk;
        logic [PWR_W-1:0] pw;
        logic             e_cook, e_pause;
        logic [PWR_W-1:0] e_lvl;
        logic             e_mag;
    } vec_t;

    vec_t vecs[NV];
    logic [W-1:0] exp_q[$];

    function automatic vec_t mk(input logic sn, pn, cn, dr, tm, tk, input int pw,
                                input logic ec, ep, input int el, input logic em);
        vec_t v;
        v.sn = sn; v.pn = pn; v.cn = cn; v.dr = dr; v.tm = tm; v.tk = tk;
        v.pw = PWR_W'(pw); v.e_cook = ec; v.e_pause = ep; v.e_lvl = PWR_W'(el); v.e_mag = em;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic apply(input logic sn, pn, cn, dr, tm, tk, input int pw);
        @(negedge clk);
        bus.startn = sn; bus.stopn = pn; bus.clearn = cn;
        bus.door_closed = dr; bus.timer_done = tm; bus.tick = tk;
        bus.power_level = PWR_W'(pw);
    endtask

    task automatic idle_in(input logic tk);
        apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, tk, 0);
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic sb_pop(input int idx);
        logic [W-1:0] act;
        logic [W-1:0] exp;
        act = {bus.cooking, bus.paused, bus.level_q, bus.mag_on};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL vec%0d: scoreboard empty, got %b", idx, act);
        end else begin
            exp = exp_q.pop_front();
            if (act !== exp) begin
                errors++;
                $display("FAIL vec%0d {cook,pause,lvl,mag}: got %b expected %b", idx, act, exp);
            end
        end
    endtask

    // ---------------- test ----------------
    initial begin
        int   model_slot;
        int   highs;
        logic exp_mag;

        checks = 0;
        errors = 0;
        resetn = 1'b0;
        bus.startn = 1'b1; bus.stopn = 1'b1; bus.clearn = 1'b1;
        bus.door_closed = 1'b1; bus.timer_done = 1'b0; bus.tick = 1'b0;
        bus.power_level = '0;

        //          sn pn cn dr tm tk pw  cook pause lvl mag
        vecs[0]  = mk(1, 1, 1, 1, 0, 0, 7,  0, 0, 0,  0);
        vecs[1]  = mk(0, 1, 1, 1, 0, 0, 7,  1, 0, 7,  1);
        vecs[2]  = mk(1, 1, 1, 1, 0, 0, 2,  1, 0, 7,  1);
        vecs[3]  = mk(1, 1, 1, 1, 0, 1, 2,  1, 0, 7,  1);
        vecs[4]  = mk(1, 0, 1, 1, 0, 0, 2,  0, 1, 7,  0);
        vecs[5]  = mk(0, 0, 1, 1, 0, 0, 2,  0, 1, 7,  0);
        vecs[6]  = mk(0, 1, 1, 1, 0, 0, 2,  1, 0, 7,  1);
        vecs[7]  = mk(1, 0, 0, 1, 0, 0, 2,  0, 0, 0,  0);
        vecs[8]  = mk(0, 1, 1, 0, 0, 0, 5,  0, 0, 0,  0);
        vecs[9]  = mk(0, 1, 1, 1, 1, 0, 5,  0, 0, 0,  0);
        vecs[10] = mk(0, 1, 1, 1, 0, 0, 15, 1, 0, 10, 1);
        vecs[11] = mk(1, 1, 1, 1, 1, 0, 15, 0, 0, 0,  0);
        vecs[12] = mk(0, 1, 1, 1, 0, 0, 0,  1, 0, 0,  0);
        vecs[13] = mk(1, 1, 1, 1, 0, 1, 0,  1, 0, 0,  0);
        vecs[14] = mk(1, 0, 1, 1, 0, 0, 0,  0, 1, 0,  0);
        vecs[15] = mk(1, 1, 1, 1, 1, 0, 0,  0, 0, 0,  0);
        vecs[16] = mk(0, 1, 1, 1, 0, 1, 3,  1, 0, 3,  1);
        vecs[17] = mk(1, 1, 1, 0, 0, 0, 3,  0, 1, 3,  0);
        vecs[18] = mk(1, 1, 0, 1, 0, 0, 3,  0, 0, 0,  0);

        // Reset state
        edge_sample();
        chk("rst_cooking", bus.cooking, 0);
        chk("rst_paused", bus.paused, 0);
        chk("rst_level", bus.level_q, 0);
        chk("rst_mag", bus.mag_on, 0);
        @(negedge clk);
        resetn = 1'b1;

        // Table-driven vectors through the scoreboard
        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].sn, vecs[i].pn, vecs[i].cn, vecs[i].dr, vecs[i].tm, vecs[i].tk, vecs[i].pw);
            exp_q.push_back({vecs[i].e_cook, vecs[i].e_pause, vecs[i].e_lvl, vecs[i].e_mag});
            edge_sample();
            sb_pop(i);
        end

        // Duty cycle at level 3 over 20 ticks
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 3);
        edge_sample();
        chk("duty_cooking", bus.cooking, 1);
        chk("duty_level", bus.level_q, 3);
        model_slot = 0;
        highs = 0;
        for (int i = 0; i < 20; i++) begin
            apply(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 3);
            #1;
            exp_mag = (model_slot < 3);
            chk("duty_mag", bus.mag_on, exp_mag);
            if (bus.mag_on) highs++;
            edge_sample();
            model_slot = (model_slot == 9) ? 0 : model_slot + 1;
            idle_in(1'b0);
            edge_sample();
        end
        chk("duty_highs", highs, 6);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3);
        edge_sample();
        chk("duty_clear", bus.cooking, 0);

        // Door open in COOK at level 10, then resume
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10);
        edge_sample();
        for (int i = 0; i < 3; i++) begin
            idle_in(1'b1);
            edge_sample();
        end
        chk("door_slot_before", bus.dbg_slot, 3);
        apply(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        #1;
        chk("door_mag_same_cycle", bus.mag_on, 0);
        chk("door_paused_same_cycle", bus.paused, 0);
        edge_sample();
        chk("door_paused_next", bus.paused, 1);
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2);
        edge_sample();
        chk("door_resume_cook", bus.cooking, 1);
        chk("door_resume_slot", bus.dbg_slot, 0);
        chk("door_resume_level", bus.level_q, 10);
        chk("door_resume_mag", bus.mag_on, 1);
        apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        edge_sample();

        // Clamp (15 -> 10, always on) and zero level (never on)
        for (int k = 0; k < 2; k++) begin
            apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (k == 0) ? 15 : 0);
            edge_sample();
            chk("clamp_level", bus.level_q, (k == 0) ? 10 : 0);
            for (int i = 0; i < 12; i++) begin
                idle_in(i[0]);
                #1;
                chk("clamp_mag", bus.mag_on, (k == 0) ? 1 : 0);
                chk("clamp_cooking", bus.cooking, 1);
                edge_sample();
            end
            apply(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 0);
            edge_sample();
        end

        // Asynchronous reset mid-cook
        apply(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5);
        edge_sample();
        for (int c = 0; c < 10; c++) begin
            idle_in((c % 4) == 0);
            edge_sample();
        end
        chk("rstmid_slot", bus.dbg_slot, 3);
        chk("rstmid_mag_before", bus.mag_on, 1);
        @(negedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rstmid_mag", bus.mag_on, 0);
        chk("rstmid_cooking", bus.cooking, 0);
        chk("rstmid_level", bus.level_q, 0);
        @(negedge clk);
        resetn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle_in(1'b1);
            edge_sample();
            chk("rstmid_stay_idle", {bus.cooking, bus.paused}, 0);
        end

        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL sb_leftover: got %0d entries expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
